// File: rtl/k_aud_cmprs_pkg.sv
// Shared constants for the audio compressor datapath.
// Neighbouring blocks use ENERGY_LATENCY to align side-band data such as bin index.
package k_aud_cmprs_pkg;

    localparam int DEF_IN_WIDTH   = 16;
    localparam int DEF_OUT_WIDTH  = 40;
    localparam int ENERGY_LATENCY = 3;

endpackage : k_aud_cmprs_pkg

// File: rtl/k_energy_compute_if.sv
// AXI-Stream-style complex sample channel feeding the energy unit.
// The tdata layout is {re, im}, with each component signed and IN_WIDTH bits wide.
interface k_energy_compute_if
    import k_aud_cmprs_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH
) ();

    logic                    tvalid;
    logic                    tready;
    logic [2*IN_WIDTH-1:0]   tdata;

    modport master (output tvalid, output tdata, input  tready);
    modport slave  (input  tvalid, input  tdata, output tready);

endinterface : k_energy_compute_if

// File: rtl/k_signed_square.sv
// Registered signed square: W-bit two's-complement in, 2W-bit unsigned out.
// The square of any signed value is non-negative, so the reinterpretation is lossless.
module k_signed_square #(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic signed [W-1:0]  a,
    output logic [2*W-1:0]       sq
);

    logic signed [2*W-1:0] a_ext_s;
    logic signed [2*W-1:0] prod_s;

    // Sign-extend first so the product is formed at full 2W width.
    always_comb begin
        a_ext_s = {{W{a[W-1]}}, a};
        prod_s  = a_ext_s * a_ext_s;
    end

    // Product register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sq <= '0;
        end else begin
            sq <= $unsigned(prod_s);
        end
    end

endmodule : k_signed_square

// File: rtl/k_energy_compute.sv
// Streaming per-bin energy (re^2 + im^2) with a fixed three-stage pipeline and no stall path.
// Output is zero-extended or saturated to OUT_WIDTH and never wraps.
module k_energy_compute
    import k_aud_cmprs_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    k_energy_compute_if.slave     s_axis,
    output logic [OUT_WIDTH-1:0]  out_energy,
    output logic                  out_valid
);

    localparam int SUM_W = 2 * IN_WIDTH;

    logic                        tready_r;
    logic                        accept_s;
    logic signed [IN_WIDTH-1:0]  re_r;
    logic signed [IN_WIDTH-1:0]  im_r;
    logic                        v1_r;
    logic                        v2_r;
    logic [SUM_W-1:0]            sq_re_s;
    logic [SUM_W-1:0]            sq_im_s;
    logic [SUM_W-1:0]            sum_s;
    logic [OUT_WIDTH-1:0]        sat_s;

    assign s_axis.tready = tready_r;
    assign accept_s      = s_axis.tvalid && tready_r;

    // S1: ready flag, input capture and first valid stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tready_r <= 1'b0;
            v1_r     <= 1'b0;
            re_r     <= '0;
            im_r     <= '0;
        end else begin
            tready_r <= 1'b1;
            v1_r     <= accept_s;
            if (accept_s) begin
                re_r <= $signed(s_axis.tdata[2*IN_WIDTH-1:IN_WIDTH]);
                im_r <= $signed(s_axis.tdata[IN_WIDTH-1:0]);
            end
        end
    end

    k_signed_square #(.W(IN_WIDTH)) u_sq_re (
        .clk    (clk),
        .resetn (resetn),
        .a      (re_r),
        .sq     (sq_re_s)
    );

    k_signed_square #(.W(IN_WIDTH)) u_sq_im (
        .clk    (clk),
        .resetn (resetn),
        .a      (im_r),
        .sq     (sq_im_s)
    );

    // S2: valid tracks the squarer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v2_r <= 1'b0;
        end else begin
            v2_r <= v1_r;
        end
    end

    // Max sum is 2^(SUM_W-1), so SUM_W bits hold it without carry-out.
    always_comb begin
        sum_s = sq_re_s + sq_im_s;
    end

    generate
        if (OUT_WIDTH >= SUM_W) begin : g_zext
            // Wide output: plain zero-extension.
            always_comb begin
                sat_s = OUT_WIDTH'(sum_s);
            end
        end else begin : g_sat
            // Narrow output: clamp to all-ones whenever any dropped bit is set.
            always_comb begin
                if (|sum_s[SUM_W-1:OUT_WIDTH]) begin
                    sat_s = '1;
                end else begin
                    sat_s = sum_s[OUT_WIDTH-1:0];
                end
            end
        end
    endgenerate

    // S3: result register holds between valid beats.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_energy <= '0;
        end else begin
            out_valid <= v2_r;
            if (v2_r) begin
                out_energy <= sat_s;
            end
        end
    end

endmodule : k_energy_compute

// File: tb/tb_k_energy_compute.sv
// Directed bench: a 40-bit and a 24-bit build run side by side on the same stimulus,
// checked cycle by cycle against hand-computed energies.
module tb_k_energy_compute;

    localparam int IW = 16;
    localparam int OW = 40;
    localparam int NW = 24;

    logic            clk = 1'b0;
    logic            resetn;
    logic            tvalid;
    logic [2*IW-1:0] tdata;

    logic [OW-1:0]   out_energy_w;
    logic            out_valid_w;
    logic [NW-1:0]   out_energy_n;
    logic            out_valid_n;

    int checks = 0;
    int errors = 0;

    logic            tv_q [0:31];
    logic [2*IW-1:0] td_q [0:31];
    logic [OW-1:0]   ew_q [0:31];
    logic [NW-1:0]   en_q [0:31];
    int              n_cyc;
    logic [OW-1:0]   hold_w;
    logic [NW-1:0]   hold_n;
    logic            exp_v;

    always #5 clk = ~clk;

    k_energy_compute_if #(.IN_WIDTH(IW)) axis_w ();
    k_energy_compute_if #(.IN_WIDTH(IW)) axis_n ();

    assign axis_w.tvalid = tvalid;
    assign axis_w.tdata  = tdata;
    assign axis_n.tvalid = tvalid;
    assign axis_n.tdata  = tdata;

    k_energy_compute #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut_w (
        .clk        (clk),
        .resetn     (resetn),
        .s_axis     (axis_w.slave),
        .out_energy (out_energy_w),
        .out_valid  (out_valid_w)
    );

    k_energy_compute #(.IN_WIDTH(IW), .OUT_WIDTH(NW)) dut_n (
        .clk        (clk),
        .resetn     (resetn),
        .s_axis     (axis_n.slave),
        .out_energy (out_energy_n),
        .out_valid  (out_valid_n)
    );

    task automatic clear_vecs();
        for (int i = 0; i < 32; i++) begin
            tv_q[i] = 1'b0;
            td_q[i] = 32'h0;
            ew_q[i] = 40'h0;
            en_q[i] = 24'h0;
        end
    endtask

    task automatic set_vec(input int c, input logic [15:0] re, input logic [15:0] im,
                           input logic [39:0] ew, input logic [23:0] en);
        tv_q[c] = 1'b1;
        td_q[c] = {re, im};
        ew_q[c] = ew;
        en_q[c] = en;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        tvalid = 1'b0;
        tdata  = 32'h0;
        #1 resetn = 1'b0;
        #2;
        checks++;
        if (out_valid_w !== 1'b0 || out_energy_w !== 40'h0 || out_valid_n !== 1'b0 || out_energy_n !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b e=%h / v=%b e=%h, want 0", out_valid_w, out_energy_w, out_valid_n, out_energy_n);
        end
        checks++;
        if (axis_w.tready !== 1'b0 || axis_n.tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready: got %b/%b want 0", axis_w.tready, axis_n.tready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (axis_w.tready !== 1'b0) begin
            errors++;
            $display("FAIL tready_before_edge: got %b want 0", axis_w.tready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (axis_w.tready !== 1'b1 || axis_n.tready !== 1'b1) begin
            errors++;
            $display("FAIL tready_after_release: got %b/%b want 1", axis_w.tready, axis_n.tready);
        end
        hold_w = 40'h0;
        hold_n = 24'h0;
    endtask

    task automatic test_single_beats();
        clear_vecs();
        set_vec(0, 16'h0034, 16'h0006, 40'h00_0000_0AB4, 24'h000AB4);
        set_vec(5, 16'hFFE8, 16'h0063, 40'h00_0000_2889, 24'h002889);
        n_cyc = 10;
        for (int c = 0; c < n_cyc + 3; c++) begin
            @(posedge clk); #1;
            tvalid = (c < n_cyc) ? tv_q[c] : 1'b0;
            tdata  = (c < n_cyc) ? td_q[c] : 32'h0;
            @(negedge clk);
            exp_v = (c >= 3) ? tv_q[c-3] : 1'b0;
            if (exp_v) begin hold_w = ew_q[c-3]; hold_n = en_q[c-3]; end
            checks++;
            if (out_valid_w !== exp_v || out_energy_w !== hold_w || out_valid_n !== exp_v || out_energy_n !== hold_n) begin
                errors++;
                $display("FAIL single c=%0d: got v=%b e=%h / v=%b e=%h, want v=%b e=%h / e=%h",
                         c, out_valid_w, out_energy_w, out_valid_n, out_energy_n, exp_v, hold_w, hold_n);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_vecs();
        set_vec(0, 16'h8000, 16'h8000, 40'h00_8000_0000, 24'hFFFFFF);
        set_vec(1, 16'h7FFF, 16'h7FFF, 40'h00_7FFE_0002, 24'hFFFFFF);
        set_vec(2, 16'hFFFF, 16'hFFFF, 40'h00_0000_0002, 24'h000002);
        set_vec(3, 16'h0000, 16'h0000, 40'h00_0000_0000, 24'h000000);
        n_cyc = 4;
        for (int c = 0; c < n_cyc + 3; c++) begin
            @(posedge clk); #1;
            tvalid = (c < n_cyc) ? tv_q[c] : 1'b0;
            tdata  = (c < n_cyc) ? td_q[c] : 32'h0;
            @(negedge clk);
            exp_v = (c >= 3) ? tv_q[c-3] : 1'b0;
            if (exp_v) begin hold_w = ew_q[c-3]; hold_n = en_q[c-3]; end
            checks++;
            if (out_valid_w !== exp_v || out_energy_w !== hold_w || out_valid_n !== exp_v || out_energy_n !== hold_n) begin
                errors++;
                $display("FAIL b2b c=%0d: got v=%b e=%h / v=%b e=%h, want v=%b e=%h / e=%h",
                         c, out_valid_w, out_energy_w, out_valid_n, out_energy_n, exp_v, hold_w, hold_n);
            end
        end
    endtask

    task automatic test_gapped();
        int k;
        int e;
        logic [39:0] ev;
        clear_vecs();
        k = 0;
        n_cyc = 22;
        for (int c = 0; c < n_cyc; c++) begin
            if ((c % 7) < 5) begin
                e  = 2 * (k + 1) * (k + 1);
                ev = 40'(e);
                set_vec(c, 16'(k + 1), 16'(-(k + 1)), ev, ev[23:0]);
                k++;
            end
        end
        for (int c = 0; c < n_cyc + 3; c++) begin
            @(posedge clk); #1;
            tvalid = (c < n_cyc) ? tv_q[c] : 1'b0;
            tdata  = (c < n_cyc) ? td_q[c] : 32'h0;
            @(negedge clk);
            exp_v = (c >= 3) ? tv_q[c-3] : 1'b0;
            if (exp_v) begin hold_w = ew_q[c-3]; hold_n = en_q[c-3]; end
            checks++;
            if (out_valid_w !== exp_v || out_energy_w !== hold_w || out_valid_n !== exp_v || out_energy_n !== hold_n) begin
                errors++;
                $display("FAIL gapped c=%0d: got v=%b e=%h / v=%b e=%h, want v=%b e=%h / e=%h",
                         c, out_valid_w, out_energy_w, out_valid_n, out_energy_n, exp_v, hold_w, hold_n);
            end
        end
    endtask

    task automatic test_narrow();
        clear_vecs();
        set_vec(0, 16'h7FFF, 16'h7FFF, 40'h00_7FFE_0002, 24'hFFFFFF);
        set_vec(1, 16'h0034, 16'h0006, 40'h00_0000_0AB4, 24'h000AB4);
        n_cyc = 2;
        for (int c = 0; c < n_cyc + 3; c++) begin
            @(posedge clk); #1;
            tvalid = (c < n_cyc) ? tv_q[c] : 1'b0;
            tdata  = (c < n_cyc) ? td_q[c] : 32'h0;
            @(negedge clk);
            exp_v = (c >= 3) ? tv_q[c-3] : 1'b0;
            if (exp_v) begin hold_w = ew_q[c-3]; hold_n = en_q[c-3]; end
            checks++;
            if (out_valid_n !== exp_v || out_energy_n !== hold_n || out_energy_w !== hold_w) begin
                errors++;
                $display("FAIL narrow c=%0d: got v=%b e=%h (wide e=%h), want v=%b e=%h (wide e=%h)",
                         c, out_valid_n, out_energy_n, out_energy_w, exp_v, hold_n, hold_w);
            end
        end
    endtask

    task automatic test_reset_midstream();
        clear_vecs();
        set_vec(0, 16'h0034, 16'h0006, 40'h00_0000_0AB4, 24'h000AB4);
        set_vec(1, 16'h7FFF, 16'h7FFF, 40'h00_7FFE_0002, 24'hFFFFFF);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            tvalid = tv_q[c];
            tdata  = td_q[c];
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
        tdata  = 32'h0;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (out_valid_w !== 1'b0 || out_energy_w !== 40'h0 || out_valid_n !== 1'b0 || out_energy_n !== 24'h0) begin
            errors++;
            $display("FAIL midreset_async: got v=%b e=%h / v=%b e=%h, want 0", out_valid_w, out_energy_w, out_valid_n, out_energy_n);
        end
        checks++;
        if (axis_w.tready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_tready: got %b want 0", axis_w.tready);
        end
        hold_w = 40'h0;
        hold_n = 24'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid_w !== 1'b0 || out_valid_n !== 1'b0) begin
                errors++;
                $display("FAIL midreset_hold i=%0d: got v=%b/%b want 0", i, out_valid_w, out_valid_n);
            end
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (axis_w.tready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release_tready: got %b want 1", axis_w.tready);
        end
        clear_vecs();
        set_vec(2, 16'hFFE8, 16'h0063, 40'h00_0000_2889, 24'h002889);
        n_cyc = 4;
        for (int c = 0; c < n_cyc + 3; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            tvalid = (c < n_cyc) ? tv_q[c] : 1'b0;
            tdata  = (c < n_cyc) ? td_q[c] : 32'h0;
            @(negedge clk);
            exp_v = (c >= 3) ? tv_q[c-3] : 1'b0;
            if (exp_v) begin hold_w = ew_q[c-3]; hold_n = en_q[c-3]; end
            checks++;
            if (out_valid_w !== exp_v || out_energy_w !== hold_w || out_valid_n !== exp_v || out_energy_n !== hold_n) begin
                errors++;
                $display("FAIL post_reset c=%0d: got v=%b e=%h / v=%b e=%h, want v=%b e=%h / e=%h",
                         c, out_valid_w, out_energy_w, out_valid_n, out_energy_n, exp_v, hold_w, hold_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beats();
        test_back_to_back();
        test_gapped();
        test_narrow();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_k_energy_compute
